counter_clock_downsample: RTL and testbench



---
 rtl/counter_clock_downsample.sv | 30 +++
 tb/tb_counter_clock_downsample.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/counter_clock_downsample.sv
// rtl/counter_clock_downsample.sv - programmable integer clock divider, half-period = val_i+1 input cycles
module counter_clock_downsample #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] val_i,
    output logic               clk_r_o
);

    logic [width_p-1:0] cnt_r;
    logic               half_done;

    // Half-period ends once the count reaches val_i; >= lets a lowered val_i end it on the next edge without wrapping
    assign half_done = (cnt_r >= val_i);

    // Counter and output flop share one async reset so the divided clock drops immediately on reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r   <= '0;
            clk_r_o <= 1'b0;
        end else if (half_done) begin
            cnt_r   <= '0;
            clk_r_o <= ~clk_r_o;
        end else begin
            cnt_r   <= cnt_r + width_p'(1);
        end
    end

endmodule

// File: tb/tb_counter_clock_downsample.sv
// tb/tb_counter_clock_downsample.sv - scoreboard bench for counter_clock_downsample
module tb_counter_clock_downsample;

    localparam int W = 4;

    logic         clk_i;
    logic         reset_i;
    logic [W-1:0] val_i;
    logic         clk_r_o;

    counter_clock_downsample #(.width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .val_i   (val_i),
        .clk_r_o (clk_r_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Expected length, in clk_i rising edges, of each clk_r_o phase ending at a toggle
    int exp_q[$];
    string name_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_phase(input string name, input int edges);
        exp_q.push_back(edges);
        name_q.push_back(name);
    endtask

    // Monitor: counts input edges since the last clk_r_o toggle and scores each toggle
    initial begin : monitor
        int   edge_cnt;
        logic prev;
        edge_cnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                edge_cnt = 0;
                prev = clk_r_o;
            end else begin
                edge_cnt++;
                if (clk_r_o != prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_toggle: got toggle after %0d edges expected none at t=%0t",
                                 edge_cnt, $time);
                    end else begin
                        check(name_q.pop_front(), edge_cnt, exp_q.pop_front());
                    end
                    edge_cnt = 0;
                    prev = clk_r_o;
                end
            end
        end
    end

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d pending toggles expected 0", name, exp_q.size());
        exp_q.delete();
        name_q.delete();
    endtask

    initial begin : stimulus
        reset_i = 1'b1;
        val_i   = '0;

        // Reset state
        @(negedge clk_i);
        check("reset_out_0", int'(clk_r_o), 0);
        @(negedge clk_i);
        check("reset_out_1", int'(clk_r_o), 0);
        expect_phase("rst_first_rise", 1);
        expect_phase("rst_low", 1);
        expect_phase("rst_high_rise", 1);
        #1 reset_i = 1'b0;
        drain("reset", 20);

        // Full sweep: value changed just after a rising edge, one full period measured
        for (int v = 0; v < 16; v++) begin
            val_i = W'(v);
            expect_phase($sformatf("sweep%0d_high", v), v + 1);
            expect_phase($sformatf("sweep%0d_low", v), v + 1);
            drain($sformatf("sweep%0d", v), 2 * (v + 1) + 10);
        end

        // Maximum value: both phases 16 edges
        val_i = 4'd15;
        expect_phase("max_high", 16);
        expect_phase("max_low", 16);
        drain("max", 50);

        // Decrease mid-count: 10 edges into a high phase, drop to 3
        expect_phase("dec_cut_high", 11);
        expect_phase("dec_low", 4);
        expect_phase("dec_high", 4);
        expect_phase("dec_low2", 4);
        repeat (10) @(negedge clk_i);
        #1 val_i = 4'd3;
        drain("decrease", 40);

        // Reset mid-operation while output is high
        val_i = 4'd5;
        repeat (3) @(negedge clk_i);
        #1;
        check("pre_reset_high", int'(clk_r_o), 1);
        reset_i = 1'b1;
        #1;
        check("async_drop", int'(clk_r_o), 0);
        @(negedge clk_i);
        check("hold_reset_0", int'(clk_r_o), 0);
        @(negedge clk_i);
        check("hold_reset_1", int'(clk_r_o), 0);
        expect_phase("post_rst_first_rise", 6);
        expect_phase("post_rst_low", 6);
        expect_phase("post_rst_high_rise", 6);
        #1 reset_i = 1'b0;
        drain("reset_mid", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
